// File: rtl/me_window_loader.sv
// me_window_loader: fills the banked current-MB and search-window memories read by `me`.
//
// Accepts a raster pixel stream (16x16 current macroblock, then 48x48 search window),
// writes it into MACRO_DIM current banks (bank = column, word = row) and PORT_WIDTH
// search banks (bank = col mod PORT_WIDTH, word = (col div PORT_WIDTH)*SEARCH_DIM + row),
// then starts `me` and waits for its result before accepting another load.
//
// Optional feature: define ME_LOADER_AUTOSTART_EN to pulse me_start automatically in the
// single ARM cycle; without it the `go` input gates the pulse.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   load_start       request a load (honoured only in IDLE)
//   in_valid/in_pixel/in_ready  raster pixel stream handshake
//   me_start         one-cycle start pulse to `me`
//   me_valid         `me` result valid; ends the serve phase
//   rd_addr, rd_amt  read address and search-bank rotation from `me`
//   pixel_cpr_out    current-MB read port, one byte per bank
//   pixel_spr_out    search read port, one byte per lane
//   done             one-cycle pulse when me_valid is seen in SERVE
//   go               start gate for `me` (absent with ME_LOADER_AUTOSTART_EN)
module me_window_loader #(
  parameter int unsigned MACRO_DIM  = 16,
  parameter int unsigned SEARCH_DIM = 48,
  localparam int unsigned PORT_WIDTH = MACRO_DIM + 1,
  localparam int unsigned S_DEPTH    = SEARCH_DIM * (SEARCH_DIM / MACRO_DIM),
  localparam int unsigned AW         = $clog2(S_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_start,
  input  logic                            in_valid,
  input  logic [7:0]                      in_pixel,
  output logic                            in_ready,
  output logic                            me_start,
  input  logic                            me_valid,
`ifdef ME_LOADER_AUTOSTART_EN
`else
  input  logic                            go,
`endif
  input  logic [AW-1:0]                   rd_addr,
  input  logic [5:0]                      rd_amt,
  output logic [MACRO_DIM-1:0][7:0]       pixel_cpr_out,
  output logic [PORT_WIDTH-1:0][7:0]      pixel_spr_out,
  output logic                            done
);

  localparam int unsigned CW  = $clog2(SEARCH_DIM);  // row/column counter width
  localparam int unsigned CAW = $clog2(MACRO_DIM);   // current-bank word address width
  localparam int unsigned BW  = $clog2(PORT_WIDTH);  // search-bank index width

  typedef enum logic [2:0] {
    StIdle,
    StLoadCur,
    StLoadSrch,
    StArm,
    StServe
  } state_e;

  state_e          r_state;
  logic [CW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic            r_in_ready;

  // Storage is deliberately not reset; unwritten words read as X.
  logic [7:0]      r_cur  [MACRO_DIM][MACRO_DIM];
  logic [7:0]      r_srch [PORT_WIDTH][S_DEPTH];

  logic            w_beat;
  logic            w_go;
  logic [CW-1:0]   w_dim_last;
  logic            w_col_last;
  logic            w_row_last;
  logic [BW-1:0]   w_wr_bank;
  logic [AW-1:0]   w_wr_word;

`ifdef ME_LOADER_AUTOSTART_EN
  assign w_go = 1'b1;
`else
  assign w_go = go;
`endif

  // in_ready is registered and only high in the LOAD states, so w_beat implies a LOAD state.
  assign w_beat     = in_valid & r_in_ready;
  assign w_dim_last = (r_state == StLoadCur) ? CW'(MACRO_DIM - 1) : CW'(SEARCH_DIM - 1);
  assign w_col_last = (r_col == w_dim_last);
  assign w_row_last = (r_row == w_dim_last);

  assign w_wr_bank = BW'(r_col % CW'(PORT_WIDTH));
  assign w_wr_word = AW'(r_col / CW'(PORT_WIDTH)) * AW'(SEARCH_DIM) + AW'(r_row);

  assign in_ready = r_in_ready;
  // With autostart, w_go is tied high so this reduces to "in ARM", which lasts one cycle.
  assign me_start = (r_state == StArm) & w_go;
  // Combinational so the done cycle is still SERVE and a load_start there is ignored.
  assign done     = (r_state == StServe) & me_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_row      <= '0;
      r_col      <= '0;
      r_in_ready <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (load_start) begin
            r_state    <= StLoadCur;
            r_in_ready <= 1'b1;
            r_row      <= '0;
            r_col      <= '0;
          end
        end
        StLoadCur, StLoadSrch: begin
          if (w_beat) begin
            if (w_col_last) begin
              r_col <= '0;
              if (w_row_last) begin
                r_row      <= '0;
                r_state    <= (r_state == StLoadCur) ? StLoadSrch : StArm;
                r_in_ready <= (r_state == StLoadCur);
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        StArm: begin
          if (w_go) begin
            r_state <= StServe;
          end
        end
        StServe: begin
          if (me_valid) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat) begin
      if (r_state == StLoadCur) begin
        r_cur[r_col[CAW-1:0]][r_row[CAW-1:0]] <= in_pixel;
      end else if (r_state == StLoadSrch) begin
        r_srch[w_wr_bank][w_wr_word] <= in_pixel;
      end
    end
  end

  for (genvar l = 0; l < MACRO_DIM; l++) begin : g_cpr
    assign pixel_cpr_out[l] = (rd_addr < AW'(MACRO_DIM)) ? r_cur[l][rd_addr[CAW-1:0]] : 8'd0;
  end

  // Lane l reads the bank rotated by rd_amt, modulo the bank count.
  for (genvar l = 0; l < PORT_WIDTH; l++) begin : g_spr
    logic [BW-1:0] w_bank;
    assign w_bank = BW'((l + 32'(rd_amt)) % PORT_WIDTH);
    assign pixel_spr_out[l] = (rd_addr < AW'(S_DEPTH)) ? r_srch[w_bank][rd_addr] : 8'd0;
  end

endmodule

// File: doc/me_window_loader.md
Name: me_window_loader

Overview:
- Memory-side partner of the motion-estimation core `me`; it fills the memories that `me` reads.
- Accepts a raster pixel stream: first the 16x16 current macroblock, then the 48x48 search window.
- Writes them into the banked layout `me` expects: MACRO_DIM current banks and MACRO_DIM+1 search banks.
- Serves `me` read requests (addr, amt) combinationally, starts `me`, and waits for its `valid` before accepting the next load.

Parameters:
- MACRO_DIM, 16, macroblock edge in pixels; number of current-picture banks.
- SEARCH_DIM, 48, search-window edge in pixels.
- PORT_WIDTH, MACRO_DIM+1, number of search banks (derived; not overridden).
- S_DEPTH, SEARCH_DIM*(SEARCH_DIM/MACRO_DIM), words per search bank (144).
- AW, $clog2(S_DEPTH), read address width (8).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  request a new load; honoured only in IDLE
- in_valid  in  1  pixel beat valid
- in_pixel  in  8  pixel value, raster order (row-major)
- in_ready  out  1  loader accepts a beat this cycle
- me_start  out  1  one-cycle pulse that starts `me`
- me_valid  in  1  `me` result valid; ends the serve phase
- rd_addr  in  AW  read address driven by `me`
- rd_amt  in  6  search-bank rotation driven by `me`
- pixel_cpr_out  out  8 x MACRO_DIM  current-MB read port
- pixel_spr_out  out  8 x PORT_WIDTH  search read port
- done  out  1  one-cycle pulse when `me_valid` is seen
- go  in  1  present only without ME_LOADER_AUTOSTART_EN

Behaviour:
- Storage layout:
  - Current MB: bank = column, word = row.
  - Search window: bank = col mod 17, word = (col div 17)*48 + row.
  - Memory is not reset. Unwritten words, including those for columns 48..50, return X until written; a bench must not check them.
- Read ports are combinational, zero latency:
  - pixel_cpr_out[l] = cur[bank l][rd_addr]. Returns 0 when rd_addr >= MACRO_DIM.
  - pixel_spr_out[l] = srch[bank (l+rd_amt) mod PORT_WIDTH][rd_addr]. Returns 0 when rd_addr >= S_DEPTH. Reads are valid in every state.
- States:
  - IDLE: in_ready=0. Goes to LOAD_CUR when load_start=1.
  - LOAD_CUR: in_ready=1. Each beat (in_valid & in_ready) writes a pixel and advances col, then row at col=15. After the 256th beat goes to LOAD_SRCH with counters cleared.
  - LOAD_SRCH: in_ready=1. Same beat handling with column wrap at 47. After the 2304th beat goes to ARM.
  - ARM: in_ready=0. Issues me_start (see Optional Feature), then goes to SERVE.
  - SERVE: in_ready=0. Waits for me_valid=1, then pulses done for one cycle and returns to IDLE.
- A beat is written in the cycle it is accepted; the next state takes effect one cycle after the last beat.
- load_start outside IDLE is ignored.
- Beats offered while in_ready=0 are not consumed.
- me_valid outside SERVE is ignored.
- Reset values: state IDLE; counters 0; in_ready 0; me_start 0; done 0.
- Asynchronous reset mid-load returns to IDLE immediately. Partially written memory is kept, and the next load overwrites it from pixel 0.
- Back-to-back: load_start sampled in the same cycle as done is ignored; load_start is accepted from the next cycle.

Optional Feature:
- Macro ME_LOADER_AUTOSTART_EN.
- Defined: the go port is absent. me_start pulses in the single ARM cycle, the cycle after the last search beat.
- Undefined: the go port exists. ARM holds until go=1, then pulses me_start in that cycle and moves to SERVE. go in any other state is ignored.

Test Plan:
- Reset, then load_start with 256 cur pixels (value = row*16+col) followed by 2304 search pixels (value = (row+col) & 0xFF), in_valid held high:
  - in_ready high for exactly 2560 cycles.
  - me_start pulses once (AUTOSTART on) the cycle after the last beat.
- After the load, rd_addr=5 -> pixel_cpr_out[l] = 0x50+l for l=0..15.
- After the load, rd_addr=48+7 (k=1, row 7) with rd_amt=0 -> pixel_spr_out[l] = (7+17+l) & 0xFF. With rd_amt=3, lane 0 returns bank 3 = 27.
- in_valid toggled randomly (50%) during the load:
  - Memory contents are identical to the back-to-back case.
  - No beat is accepted outside LOAD states.
- rst_n asserted after 1000 beats, then a full reload -> state IDLE in the same cycle, and the reload produces the same results as the first test.
- In SERVE, hold load_start=1, then assert me_valid=1 for one cycle -> done pulses exactly one cycle, and load_start is ignored until the cycle after done.
- AUTOSTART undefined: go held 0 for 20 cycles -> no me_start; go=1 -> me_start pulses in that cycle.
